// File: rtl/uart_pkg.sv
// Shared definitions for the DE2-115 serial port transmitter and receiver.
// Holds the transmitter state encoding, the default bit period for
// 9600 baud from a 50 MHz clock, and the data width of a frame.
package uart_pkg;

  // Transmitter frame phases; PARITY is only reachable when the parity
  // option is compiled into uart_tx.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // 50 MHz / 9600 baud, rounded: 9600.6 baud actual.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS            = 8;

  // Parity bit that makes the frame's one-count even (odd = 0) or odd (odd = 1).
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] byte_in,
                                       input logic                 odd);
    return (^byte_in) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and uart_tx.
// A byte moves on a rising edge where VALID and READY are both high.
interface uart_tx_if;

  logic [uart_pkg::DATA_BITS-1:0] DATA;
  logic                           VALID;
  logic                           READY;

  // Producer side drives the byte and the request.
  modport master (
    output DATA,
    output VALID,
    input  READY
  );

  // Transmitter side accepts the byte and reports availability.
  modport slave (
    input  DATA,
    input  VALID,
    output READY
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and pulses bit_done for one cycle on the
// terminal count, after which it wraps to 0. A synchronous clear holds
// it at 0 so the first bit period starts exactly on the acceptance edge.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_done
);

  localparam int            CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, terminal count wraps, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == TERM)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = (cnt_q == TERM);

endmodule

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter, LSB first, idle-high line.
// Frame: start bit, 8 data bits, optional parity bit, stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit; sense
// chosen by PARITY_ODD). Without it the frame is 8N1.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, READY high, waiting for VALID
// START  | line low for one bit period
// DATA   | line = shift_q[0], shift right at each bit boundary, 8 bits
// PARITY | line = parity of the accepted byte (parity build only)
// STOP   | line high for one bit period, READY rises on its last edge
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       CLK50MHz,
  input  logic       RESET_N,
  uart_tx_if.slave   bus,
  output logic       TX
);

  tx_state_t              state_q;
  tx_state_t              state_d;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic [2:0]             bit_idx_q;
  logic [2:0]             bit_idx_d;
  logic                   tx_q;
  logic                   tx_d;
  logic                   ready_q;
  logic                   ready_d;
  logic                   accept;
  logic                   baud_clr;
  logic                   bit_done;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
  logic                   parity_d;
`else
  logic                   unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Holding the timer clear while idle makes the acceptance edge the
  // start of the first bit period.
  assign baud_clr = (state_q == IDLE);
  assign accept   = bus.VALID && ready_q;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (CLK50MHz),
    .rst_n    (RESET_N),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  // Next state, shift register, bit index and registered line level.
  // tx_d is the level for the phase being entered so TX comes straight
  // off a flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = bus.DATA;
          tx_d    = 1'b0;
          ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = calc_parity(bus.DATA, PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge CLK50MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign TX        = tx_q;
  assign bus.READY = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx at 16 clocks per bit.
module tb_uart_tx;

  localparam int N    = 16;
  localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   checks = 0;
  int   errors = 0;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (N),
    .PARITY_ODD   (PODD)
  ) dut (
    .CLK50MHz (clk),
    .RESET_N  (rst_n),
    .bus      (bus),
    .TX       (tx)
  );

  always #5 clk = ~clk;

  // Line level expected during bit slot k of a frame carrying b.
  function automatic logic model_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return logic'(($countones(b) % 2) != 0) ^ PODD;
    return 1'b1;
  endfunction

  task automatic chk(input logic got, input logic exp, input string tag);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; returns #1 after the acceptance edge.
  task automatic accept(input logic [7:0] b, input bit hold);
    chk(bus.READY, 1'b1, "ready_before_accept");
    bus.VALID = 1'b1;
    bus.DATA  = b;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.VALID = 1'b0;
      bus.DATA  = 8'($urandom);
    end
  endtask

  // Checks every cycle of the frame and the first idle cycle after it;
  // returns at the negedge of that idle cycle.
  task automatic check_frame(input logic [7:0] b, input bit disturb, input string tag);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      chk(tx, model_bit(b, j / N), $sformatf("%s_slot%0d", tag, j / N));
      chk(bus.READY, 1'b0, $sformatf("%s_ready_low", tag));
      if (disturb && j == 40) begin
        bus.VALID = 1'b1;
        bus.DATA  = 8'hFF;
      end
      if (disturb && j == 90) bus.VALID = 1'b0;
    end
    @(negedge clk);
    chk(bus.READY, 1'b1, $sformatf("%s_ready_after", tag));
    chk(tx, 1'b1, $sformatf("%s_tx_after", tag));
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      chk(tx, 1'b1, $sformatf("%s_tx", tag));
      chk(bus.READY, 1'b1, $sformatf("%s_ready", tag));
    end
  endtask

  initial begin
    logic [7:0] rb;
    bus.VALID = 1'b0;
    bus.DATA  = 8'h00;
    rst_n     = 1'b0;

    // Reset held: VALID activity must not disturb the idle outputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.VALID = ~bus.VALID;
      bus.DATA  = 8'($urandom);
      chk(tx, 1'b1, "rst_tx");
      chk(bus.READY, 1'b1, "rst_ready");
    end
    @(negedge clk);
    bus.VALID = 1'b0;
    rst_n     = 1'b1;
    idle_check(3 * N, "post_rst");

    // Single byte.
    accept(8'hA5, 1'b0);
    check_frame(8'hA5, 1'b0, "a5");
    idle_check(3, "a5_idle");

    // Back-to-back with VALID held: second start bit follows N+1 high cycles.
    accept(8'h00, 1'b1);
    check_frame(8'h00, 1'b0, "b2b0");
    accept(8'hFF, 1'b1);
    check_frame(8'hFF, 1'b0, "b2b1");
    bus.VALID = 1'b0;
    idle_check(3, "b2b_idle");

    // VALID pulse and DATA change while busy.
    accept(8'h3C, 1'b0);
    check_frame(8'h3C, 1'b1, "busy");
    idle_check(5, "busy_idle");

    // Random bytes.
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      accept(rb, 1'b0);
      check_frame(rb, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset during data bit 3 (0xF0 has bit 3 low, so TX must rise).
    accept(8'hF0, 1'b0);
    repeat (4 * N + N / 2) @(negedge clk);
    chk(tx, 1'b0, "pre_reset_tx");
    chk(bus.READY, 1'b0, "pre_reset_ready");
    rst_n = 1'b0;
    #1;
    chk(tx, 1'b1, "async_rst_tx");
    chk(bus.READY, 1'b1, "async_rst_ready");
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2, "rst2_idle");
    accept(8'h81, 1'b0);
    check_frame(8'h81, 1'b0, "after_rst_81");

`ifdef UART_TX_PARITY_EN
    accept(8'h07, 1'b0);
    check_frame(8'h07, 1'b0, "par07");
    accept(8'h03, 1'b0);
    check_frame(8'h03, 1'b0, "par03");
`endif

    idle_check(4, "final_idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter for the DE2-115 design. Paired with the 9600-baud receiver on the board's serial port; default frame is 8N1. Accepts one byte per valid/ready handshake and shifts it out LSB-first on TX. Driven by the on-board 50 MHz clock.

## Interface
- CLKS_PER_BIT, default 5208: CLK50MHz cycles per bit period (50 MHz / 9600 baud); legal range ≥ 2.
- PARITY_ODD, default 0: parity sense (0 = even, 1 = odd); used only when UART_TX_PARITY_EN is defined.
- CLK50MHz  input  1: sole clock, rising edge.
- RESET_N  input  1: asynchronous, active-low reset.
- DATA  input  8: byte to send; sampled only on the acceptance cycle.
- VALID  input  1: DATA is valid and a frame is requested.
- READY  output  1: the block can accept a byte this cycle.
- TX  output  1: serial line; idles high.

## Operation
- Reset values (asynchronous, while RESET_N is low):
  - TX = 1, READY = 1, state = IDLE.
  - Bit counter and baud counter = 0, shift register = 0.
- Acceptance occurs on a rising edge where VALID && READY. DATA is latched into the shift register and READY drops on the same edge.
- States:
  - IDLE: TX = 1, READY = 1. On acceptance, go to START.
  - START: TX = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TX = shift[0] for CLKS_PER_BIT cycles per bit, 8 bits, LSB first.
    - Shift right at each bit boundary.
    - After bit 7, go to PARITY (macro defined) or STOP.
  - PARITY: TX = ^byte ^ PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: TX = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1. Terminal count is the bit boundary; the counter then wraps to 0.
  - Cleared on acceptance.
- Bit index: 3 bits, counts 0..7, and is cleared on entering DATA.
- VALID outside acceptance, and DATA changes mid-frame, have no effect.
- RESET_N asserted mid-frame aborts the frame immediately: TX = 1 and READY = 1 without waiting for a clock. The partial frame is lost.
- TX is driven directly from a flop (glitch-free). There is no combinational path from any input to TX or READY.

## Timing
- The edge that accepts the byte also drives TX low, so TX falls one cycle after the cycle in which VALID && READY was seen.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- READY rises on the edge that ends the stop bit.
- Back-to-back traffic with VALID held high:
  - The next acceptance happens on the first IDLE cycle.
  - The line therefore stays high for CLKS_PER_BIT+1 cycles between frames.
  - Sustained throughput is one byte per 10·CLKS_PER_BIT+1 cycles.
- Default rate: 5208 cycles/bit gives 9600.6 baud (+0.006 % error).

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is compiled in; the frame is 8 data + 1 parity + 1 stop.
  - Parity sense is set by PARITY_ODD.
- UART_TX_PARITY_EN undefined:
  - No PARITY state or parity logic; the frame is 8N1.
  - PARITY_ODD is ignored.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - DEFAULT_CLKS_PER_BIT = 5208;
  - DATA_BITS = 8.
- The receiver uses the same package.
- One sub-module, uart_baud_gen, carries CLKS_PER_BIT:
  - inputs: clock, reset, synchronous clear;
  - output: one-cycle bit_done pulse at terminal count.
- The transmitter FSM and shift register live in uart_tx.

## Test plan
- Reset: hold RESET_N low, toggle VALID → TX = 1, READY = 1 throughout. Release reset → idle with no frame emitted.
- Single byte 0xA5, CLKS_PER_BIT = 16:
  - Sample TX at each bit centre → 0,1,0,1,0,0,1,0,1,1.
  - Frame lasts 160 cycles; READY is low for exactly 160 cycles.
- Back-to-back: VALID held high with 0x00 then 0xFF → two correct frames, with the line high for exactly 17 cycles between the start bits' preceding idle and the next start bit.
- Busy immunity: during frame 0x3C, pulse VALID and change DATA to 0xFF → 0x3C is sent intact, no extra acceptance occurs, and READY stays low.
- Reset mid-frame: assert RESET_N during data bit 3 → TX goes to 1 and READY to 1 asynchronously. The next accepted byte 0x81 is sent correctly.
- Parity (macro defined, PARITY_ODD = 0): bytes 0x07 and 0x03 → parity bits 1 and 0. Frame lasts 176 cycles at CLKS_PER_BIT = 16.
